stack_drain_ctl: RTL and testbench

- Reader-side controller for the team's LIFO stack. It empties a stack and streams its contents to a downstream consumer.
- On `start`, it issues single-cycle pop requests to the stack and captures each popped word after a fixed read latency.
- Each captured word goes out on a valid/ready interface, top-of-stack first. The block repeats until the stack reports empty or an item limit is reached.
- It sits between the stack (e.g. a stored 2-bit move/direction history) and the unit that replays or consumes that history.

---
 rtl/stack_drain_if.sv | 36 +++
 rtl/stack_drain_ctl.sv | 126 ++++++++++++
 tb/tb_stack_drain_ctl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_drain_if.sv
// Bus bundle between the drain controller, the LIFO stack it pops and the
// downstream consumer of the drained words.
//
// Handshake: a word moves on every rising edge where out_valid and out_ready
// are both high. Once out_valid is raised, it and out_data stay unchanged
// until that transfer happens. out_ready may change freely, and the consumer
// may raise it before out_valid. stk_pop is a one-cycle request and carries
// no ready. The stack answers it with stk_data a fixed number of cycles later.
interface stack_drain_if #(
    parameter int WIDTH = 2
);
    logic             stk_pop;
    logic             stk_empty;
    logic [WIDTH-1:0] stk_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output stk_pop,
        output out_data,
        output out_valid,
        input  stk_empty,
        input  stk_data,
        input  out_ready
    );

    modport slave (
        input  stk_pop,
        input  out_data,
        input  out_valid,
        output stk_empty,
        output stk_data,
        output out_ready
    );
endinterface

// File: rtl/stack_drain_ctl.sv
// Reader-side drain controller for the LIFO stack. Each start pops words one
// at a time. Each word is captured a fixed latency after its pop and is then
// offered downstream, top of stack first. The drain ends when the stack is
// empty or MAX_ITEMS words have been delivered.
module stack_drain_ctl #(
    parameter int WIDTH     = 2,
    parameter int POP_LAT   = 2,
    parameter int MAX_ITEMS = 8,
    localparam int CNT_W    = $clog2(MAX_ITEMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    stack_drain_if.master    bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] count,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POP  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    // The counter runs POP_LAT-1 down to 0 across the WAIT cycles. The word is
    // captured in the cycle where the counter reads 0.
    localparam logic [3:0]       LAT_INIT = 4'(POP_LAT - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_ITEMS - 1);

    state_t             state_q, state_d;
    logic [3:0]         lat_q, lat_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic               pop;

    // State and datapath registers. Reset abandons any drain in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath decisions for the drain sequence.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = bus.stk_empty ? S_FIN : S_POP;
                end
            end
            S_POP: begin
                pop     = 1'b1;
                lat_d   = LAT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 4'd0) begin
                    data_d  = bus.stk_data;
                    valid_d = 1'b1;
                    state_d = S_OUT;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_OUT: begin
                if (valid_q && bus.out_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + CNT_W'(1);
                    if (bus.stk_empty) begin
                        state_d = S_FIN;
                    end else if (count_q == LAST_CNT) begin
                        // The item limit was reached while words remain: flag a runaway.
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_POP;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.stk_pop   = pop;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FIN);
    assign err           = err_q;
    assign count         = count_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_stack_drain_ctl.sv
// Bench for stack_drain_ctl. A behavioural LIFO with a fixed read latency
// feeds the block. Words delivered downstream are scored against the stack
// contents, top first, truncated to the item limit.
module tb_stack_drain_ctl;

  localparam int W       = 2;
  localparam int POP_LAT = 2;
  localparam int MAX     = 8;
  localparam int CNT_W   = $clog2(MAX + 1);

  typedef struct {
    int           due;
    logic [W-1:0] val;
  } pend_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] count;
  logic [2:0]       dbg_state;

  stack_drain_if #(.WIDTH(W)) bus ();

  stack_drain_ctl #(.WIDTH(W), .POP_LAT(POP_LAT), .MAX_ITEMS(MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .count       (count),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [W-1:0] stk_q[$];
  pend_t        pend_q[$];
  logic [W-1:0] exp_q[$];
  int           pop_cyc[$];
  int           rise_cyc[$];
  int           n_hs, done_seen, done_cyc, busy_cycles, start_cyc;
  int           stall_left = 0;
  bit           rnd_ready = 0;
  bit           noise = 0;
  bit           busy_nd = 0;
  bit           prev_valid = 0;
  bit           prev_ready = 1;
  logic [W-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Observe one cycle, mid-cycle.
  task automatic monitor();
    if (rst) begin
      prev_valid = 0;
      prev_ready = 1;
      busy_nd    = 0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_hs++;
        if (exp_q.size() > 0) check("word", bus.out_data, exp_q.pop_front());
      end
      if (bus.out_valid && !prev_valid) rise_cyc.push_back(cyc);
      if (bus.stk_pop) begin
        pop_cyc.push_back(cyc);
        check("pop_not_empty", stk_q.size() > 0, 1);
        check("pop_no_valid", bus.out_valid, 0);
        if (stk_q.size() > 0) pend_q.push_back('{cyc + POP_LAT, stk_q.pop_back()});
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
      end
      if (busy) busy_cycles++;
      if (bus.out_valid && stall_left > 0) stall_left--;
      busy_nd    = busy && !done;
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_data  = bus.out_data;
    end
  endtask

  // Drive inputs for the new cycle, just after the edge.
  task automatic drive();
    pend_t p;
    cyc++;
    start = noise && busy_nd && ($urandom_range(0, 2) == 0);
    bus.stk_empty = (stk_q.size() == 0);
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      p = pend_q.pop_front();
      bus.stk_data = p.val;
    end else begin
      bus.stk_data = W'($urandom);
    end
    if (stall_left > 0) bus.out_ready = 1'b0;
    else if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    else bus.out_ready = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  // Start a drain of the current model stack and check its totals.
  task automatic run_drain(input int budget);
    int n0;
    int n_exp;
    int t;
    n0    = stk_q.size();
    n_exp = (n0 > MAX) ? MAX : n0;
    exp_q.delete();
    for (int i = 0; i < n_exp; i++) exp_q.push_back(stk_q[n0 - 1 - i]);
    n_hs = 0;
    done_seen = 0;
    busy_cycles = 0;
    pop_cyc.delete();
    rise_cyc.delete();
    bus.stk_empty = (n0 == 0);
    start = 1'b1;
    start_cyc = cyc;
    t = 0;
    while (done_seen == 0 && t < budget) begin
      tick();
      t++;
    end
    for (int i = 0; i < 3; i++) tick();
    check("done_once", done_seen, 1);
    check("words_delivered", n_hs, n_exp);
    check("words_left_exp", exp_q.size(), 0);
    check("pops", pop_cyc.size(), n_exp);
    check("count", count, n_exp);
    check("err", err, (n0 > MAX) ? 1 : 0);
    check("stack_left", stk_q.size(), n0 - n_exp);
    check("idle_after", busy, 0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    start = 1'b0;
    bus.stk_empty = 1'b1;
    bus.stk_data = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_pop", bus.stk_pop, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    for (int i = 0; i < 2; i++) tick();

    // Empty stack: straight to FIN.
    stk_q.delete();
    run_drain(20);
    check("empty_busy_cycles", busy_cycles, 1);
    check("empty_done_cyc", done_cyc, start_cyc + 1);

    // Stack [bottom 2,1,3 top] drained at full rate.
    stk_q = '{2'd2, 2'd1, 2'd3};
    run_drain(60);
    if (pop_cyc.size() == 3) begin
      check("first_pop_cyc", pop_cyc[0], start_cyc + 1);
      check("pop_gap_1", pop_cyc[1] - pop_cyc[0], POP_LAT + 2);
      check("pop_gap_2", pop_cyc[2] - pop_cyc[1], POP_LAT + 2);
    end
    if (rise_cyc.size() > 0) check("first_valid_cyc", rise_cyc[0], pop_cyc[0] + POP_LAT + 1);

    // Consumer stalls the first word for 5 cycles.
    stk_q = '{2'd2, 2'd1, 2'd3};
    stall_left = 5;
    run_drain(80);
    if (pop_cyc.size() == 3) check("stall_pop_gap", pop_cyc[1] - pop_cyc[0], POP_LAT + 2 + 5);

    // Nine words against an eight-word limit, then drain the leftover.
    stk_q.delete();
    for (int i = 0; i < 9; i++) stk_q.push_back(W'($urandom));
    run_drain(150);
    run_drain(40);

    // Asynchronous reset in the middle of the second word's wait.
    stk_q = '{2'd2, 2'd1, 2'd3};
    exp_q.delete();
    exp_q.push_back(2'd3);
    pop_cyc.delete();
    bus.stk_empty = 1'b0;
    start = 1'b1;
    t = 0;
    while (pop_cyc.size() < 2 && t < 50) begin
      tick();
      t++;
    end
    check("rst_setup_pops", pop_cyc.size(), 2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pop", bus.stk_pop, 0);
    check("arst_valid", bus.out_valid, 0);
    check("arst_data", bus.out_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_count", count, 0);
    tick();
    tick();
    rst = 1'b0;
    pend_q.delete();
    exp_q.delete();
    pop_cyc.delete();
    for (int i = 0; i < 6; i++) tick();
    check("post_rst_no_pop", pop_cyc.size(), 0);
    check("post_rst_idle", busy, 0);

    // Repeated start pulses while busy are ignored.
    noise = 1;
    stk_q = '{2'd2, 2'd1, 2'd3};
    run_drain(60);
    if (pop_cyc.size() == 3) check("noise_pop_gap", pop_cyc[2] - pop_cyc[1], POP_LAT + 2);

    // Randomized drains with a random consumer.
    rnd_ready = 1;
    for (int r = 0; r < 14; r++) begin
      int n;
      n = $urandom_range(0, 11);
      if (r == 0) n = MAX;
      stk_q.delete();
      for (int i = 0; i < n; i++) stk_q.push_back(W'($urandom));
      noise = 1'($urandom_range(0, 1));
      run_drain(40 * n + 20);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
